// File: rtl/vga_pkg.sv
// Shared VGA timing description: per-axis region lengths, total/width helpers
// and the default 640x480@60 constants used by the timing generator and the tilemap renderer.
package vga_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_timing_t;

    function automatic int unsigned total(vga_timing_t t);
        return t.visible + t.front + t.sync + t.back;
    endfunction

    // Counter width able to hold 0..total-1 for one axis.
    function automatic int unsigned axis_width(vga_timing_t t);
        return $clog2(total(t));
    endfunction

    localparam vga_timing_t VGA_640X480_H = '{visible: 640, front: 16, sync: 96, back: 48};
    localparam vga_timing_t VGA_640X480_V = '{visible: 480, front: 10, sync: 2,  back: 33};
    localparam int unsigned VGA_DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: a wrapping position counter advanced by 'adv', with decode of
// the visible and sync regions and a flag for the last position before the wrap.
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE = VGA_640X480_H.visible,
    parameter int unsigned FRONT   = VGA_640X480_H.front,
    parameter int unsigned SYNC    = VGA_640X480_H.sync,
    parameter int unsigned BACK    = VGA_640X480_H.back,
    parameter int unsigned CNT_W   = $clog2(VISIBLE + FRONT + SYNC + BACK)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             visible,
    output logic             sync,
    output logic             wrap
);

    localparam vga_timing_t T = '{visible: VISIBLE, front: FRONT, sync: SYNC, back: BACK};
    localparam int unsigned TOTAL = total(T);

    // Region boundaries; sync ends before TOTAL-1 because the back porch is non-empty.
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);

    assign wrap    = (cnt == LAST);
    assign visible = (cnt < VIS_END);
    assign sync    = (cnt >= SYNC_START) && (cnt < SYNC_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v axis timers and
// registered sync, blank, coordinate and line/frame strobe outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_DEFAULT_CLK_DIV,
    parameter int unsigned H_VISIBLE = VGA_640X480_H.visible,
    parameter int unsigned H_FRONT   = VGA_640X480_H.front,
    parameter int unsigned H_SYNC    = VGA_640X480_H.sync,
    parameter int unsigned H_BACK    = VGA_640X480_H.back,
    parameter int unsigned V_VISIBLE = VGA_640X480_V.visible,
    parameter int unsigned V_FRONT   = VGA_640X480_V.front,
    parameter int unsigned V_SYNC    = VGA_640X480_V.sync,
    parameter int unsigned V_BACK    = VGA_640X480_V.back,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    output logic                         HS,
    output logic                         VS,
    output logic                         blank,
    output logic                         pix_en,
    output logic [$clog2(H_VISIBLE)-1:0] col,
    output logic [$clog2(V_VISIBLE)-1:0] row,
    output logic                         line_start,
    output logic                         frame_start
);

    localparam vga_timing_t H_T = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam vga_timing_t V_T = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int unsigned H_W   = axis_width(H_T);
    localparam int unsigned V_W   = axis_width(V_T);
    localparam int unsigned COL_W = $clog2(H_VISIBLE);
    localparam int unsigned ROW_W = $clog2(V_VISIBLE);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV == 0 || H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
            V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
            $error("vga_timing_gen: CLK_DIV and every H_*/V_* parameter must be non-zero");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             h_visible, h_sync, h_wrap, h_zero;
    logic             v_visible, v_sync, v_wrap_unused, v_zero;
    logic             v_adv;

    // The divider and both axes freeze while en is low, so resuming skips no pixel.
    assign tick = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    vga_axis_timer #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .CNT_W   (H_W)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (tick),
        .cnt     (h_cnt),
        .visible (h_visible),
        .sync    (h_sync),
        .wrap    (h_wrap)
    );

    assign v_adv = tick & h_wrap;

    vga_axis_timer #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .CNT_W   (V_W)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (v_adv),
        .cnt     (v_cnt),
        .visible (v_visible),
        .sync    (v_sync),
        .wrap    (v_wrap_unused)
    );

    assign h_zero = (h_cnt == '0);
    assign v_zero = (v_cnt == '0);

    // Outputs capture the position being left on each tick, so they change together with pix_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            blank       <= 1'b1;
            col         <= '0;
            row         <= '0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= tick;
            line_start  <= tick & h_zero & v_visible;
            frame_start <= tick & h_zero & v_zero;
            if (tick) begin
                HS    <= h_sync ? HS_POL : ~HS_POL;
                VS    <= v_sync ? VS_POL : ~VS_POL;
                blank <= ~(h_visible & v_visible);
                col   <= h_visible ? h_cnt[COL_W-1:0] : '0;
                row   <= v_visible ? v_cnt[ROW_W-1:0] : '0;
            end
        end
    end

endmodule
